llr_frame_loader: RTL and testbench

- Upstream feeder for the LDPC `decoder`.
- Accepts a serial stream of signed channel samples over a valid/ready handshake.
- Scales each sample, saturates it to ±LLR_MAX, and assembles N samples into one channel-evidence frame.
- Holds the completed frame stable on a flat output bus, with frame_valid/frame_ready, for the decoder to consume.
- Two-stage buffering: a fill buffer plus an output register, so the next frame can fill while the decoder holds the current one.

---
 rtl/llr_frame_loader.sv | 122 ++++++++++++
 tb/tb_llr_frame_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_frame_loader.sv
// rtl/llr_frame_loader.sv - scales, saturates and assembles channel samples into LLR frames
// A fill buffer collects one frame while the output register holds the previous one for the decoder.
module llr_frame_loader #(
  parameter int N       = 10,
  parameter int IN_W    = 8,
  parameter int LLR_W   = 32,
  parameter int SHIFT   = 0,
  parameter int LLR_MAX = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [N*LLR_W-1:0]   llr_flat,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 frame_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [LLR_W-1:0] POS_MAX = LLR_W'(LLR_MAX);
  localparam logic signed [LLR_W-1:0] NEG_MAX = -POS_MAX;

  if ((IN_W + SHIFT >= LLR_W) || (LLR_MAX <= 0)) begin : g_bad_params
    $error("llr_frame_loader: need IN_W+SHIFT < LLR_W and LLR_MAX > 0");
  end

  typedef enum logic {
    FILL,
    PEND
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N*LLR_W-1:0]  fill_q, fill_d;
  logic [N*LLR_W-1:0]  llr_q, llr_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;

  logic signed [LLR_W-1:0] ext_sample;
  logic signed [LLR_W-1:0] scaled;
  logic signed [LLR_W-1:0] sat_sample;

  // Sign-extend first so the shift cannot overflow (IN_W+SHIFT < LLR_W).
  always_comb begin
    ext_sample = LLR_W'($signed(in_data));
    scaled     = ext_sample <<< SHIFT;
    if (scaled > POS_MAX) begin
      sat_sample = POS_MAX;
    end else if (scaled < NEG_MAX) begin
      sat_sample = NEG_MAX;
    end else begin
      sat_sample = scaled;
    end
  end

  assign in_ready    = (state_q == FILL) && !rst;
  assign llr_flat    = llr_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fill_d        = fill_q;
    llr_d         = llr_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = 1'b0;

    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (in_valid) begin
          fill_d[int'(idx_q)*LLR_W +: LLR_W] = sat_sample;
          if ((idx_q == LAST_IDX) && in_last) begin
            idx_d   = '0;
            state_d = PEND;
          end else if ((idx_q == LAST_IDX) || in_last) begin
            // Length mismatch: drop the partial frame, stale entries get overwritten later.
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PEND: begin
        if (!frame_valid_q || frame_ready) begin
          llr_d         = fill_q;
          frame_valid_d = 1'b1;
          state_d       = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      idx_q         <= '0;
      fill_q        <= '0;
      llr_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fill_q        <= fill_d;
      llr_q         <= llr_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_llr_frame_loader.sv
// tb/tb_llr_frame_loader.sv - self-checking bench for llr_frame_loader (SHIFT=0 and SHIFT=2 instances)
module tb_llr_frame_loader;

  localparam int N     = 10;
  localparam int LLR_W = 32;
  localparam int FW    = N * LLR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          frame_ready;

  logic          in_ready0, in_ready1;
  logic [FW-1:0] llr0, llr1;
  logic          fv0, fv1;
  logic          err0, err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t tbl[20];

  llr_frame_loader #(.N(N), .IN_W(8), .LLR_W(LLR_W), .SHIFT(0), .LLR_MAX(13)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .in_last(in_last), .llr_flat(llr0), .frame_valid(fv0), .frame_ready(frame_ready),
    .frame_err(err0)
  );

  llr_frame_loader #(.N(N), .IN_W(8), .LLR_W(LLR_W), .SHIFT(2), .LLR_MAX(13)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .llr_flat(llr1), .frame_valid(fv1), .frame_ready(frame_ready),
    .frame_err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int elem(input logic [FW-1:0] f, input int k);
    return $signed(f[k*LLR_W +: LLR_W]);
  endfunction

  // Reference: multiply by 2^shift and clip to +-13.
  function automatic int model(input logic [7:0] d, input int shift);
    int v;
    v = int'($signed(d)) * (1 << shift);
    if (v > 13) return 13;
    if (v < -13) return -13;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int w;
    w        = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready0 && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready0);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_fv();
    int w;
    w = 0;
    while (!fv0 && w < 8) begin
      tick();
      w++;
    end
    check("wait_frame_valid", fv0, 1'b1);
  endtask

  task automatic send_tbl(input int base, input int cnt, input int last_at);
    for (int i = 0; i < cnt; i++) begin
      send(tbl[base+i].data, (i == last_at));
    end
  endtask

  task automatic check_tbl_frame(input int base, input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_dut0_k%0d", tag, k), elem(llr0, k), tbl[base+k].exp0);
      check($sformatf("%s_dut1_k%0d", tag, k), elem(llr1, k), tbl[base+k].exp1);
    end
  endtask

  initial begin
    logic [FW-1:0] exp_a0, exp_b0, exp_b1, exp_r0, exp_r1;
    logic [7:0]    samp[N];
    int            kind, len;

    tbl[0]  = '{8'hF3, -13, -13};
    tbl[1]  = '{8'h0D,  13,  13};
    tbl[2]  = '{8'h0D,  13,  13};
    tbl[3]  = '{8'h0D,  13,  13};
    tbl[4]  = '{8'hF3, -13, -13};
    tbl[5]  = '{8'h0D,  13,  13};
    tbl[6]  = '{8'h0D,  13,  13};
    tbl[7]  = '{8'hF3, -13, -13};
    tbl[8]  = '{8'h0D,  13,  13};
    tbl[9]  = '{8'hF3, -13, -13};
    tbl[10] = '{8'h03,   3,  12};
    tbl[11] = '{8'hFC,  -4, -13};
    tbl[12] = '{8'h7F,  13,  13};
    tbl[13] = '{8'h80, -13, -13};
    tbl[14] = '{8'h00,   0,   0};
    tbl[15] = '{8'h01,   1,   4};
    tbl[16] = '{8'hFF,  -1,  -4};
    tbl[17] = '{8'h05,   5,  13};
    tbl[18] = '{8'hF9,  -7, -13};
    tbl[19] = '{8'h64,  13,  13};

    exp_a0 = '0;
    exp_b0 = '0;
    exp_b1 = '0;
    for (int k = 0; k < N; k++) begin
      exp_a0[k*LLR_W +: LLR_W] = tbl[k].exp0;
      exp_b0[k*LLR_W +: LLR_W] = tbl[10+k].exp0;
      exp_b1[k*LLR_W +: LLR_W] = tbl[10+k].exp1;
    end

    rst         = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b1;
    tick();
    tick();
    check("reset_in_ready", in_ready0, 1'b0);
    check("reset_frame_valid", fv0, 1'b0);
    check("reset_llr_flat", llr0, '0);
    check("reset_frame_err", err0, 1'b0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready0, 1'b1);

    // Frame A, decoder ready: valid two edges after the final handshake.
    send_tbl(0, N, N - 1);
    check("latency_no_valid_yet", fv0, 1'b0);
    check("pend_in_ready_low", in_ready0, 1'b0);
    tick();
    check("frameA_valid_dut0", fv0, 1'b1);
    check("frameA_valid_dut1", fv1, 1'b1);
    check_tbl_frame(0, "frameA");
    tick();
    check("frameA_consumed", fv0, 1'b0);

    // Early in_last on sample 6, then frame B (saturation table).
    send_tbl(10, 6, 5);
    check("early_last_err", err0, 1'b1);
    check("early_last_err_dut1", err1, 1'b1);
    check("early_last_no_valid", fv0, 1'b0);
    tick();
    check("early_last_err_one_cycle", err0, 1'b0);
    send_tbl(10, N, N - 1);
    tick();
    check("frameB_valid", fv0, 1'b1);
    check_tbl_frame(10, "frameB");
    tick();

    // Backpressure: A held, missing-last error, B stalls in PEND, then swap.
    frame_ready = 1'b0;
    send_tbl(0, N, N - 1);
    tick();
    check("held_valid", fv0, 1'b1);
    check("held_frameA", llr0, exp_a0);
    send_tbl(10, N, -1);
    check("missing_last_err", err0, 1'b1);
    check("missing_last_output_kept", llr0, exp_a0);
    check("missing_last_valid_kept", fv0, 1'b1);
    send_tbl(10, N, N - 1);
    for (int c = 0; c < 3; c++) begin
      check("stall_in_ready_low", in_ready0, 1'b0);
      check("stall_output_held", llr0, exp_a0);
      check("stall_valid_held", fv0, 1'b1);
      tick();
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("swap_valid_stays", fv0, 1'b1);
    check("swap_frameB_dut0", llr0, exp_b0);
    check("swap_frameB_dut1", llr1, exp_b1);
    check("swap_in_ready_back", in_ready0, 1'b1);

    // Reset after five accepted samples.
    send_tbl(0, 5, -1);
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", in_ready0, 1'b0);
    tick();
    check("rst_clears_valid", fv0, 1'b0);
    check("rst_clears_llr", llr0, '0);
    check("rst_clears_llr_dut1", llr1, '0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready0, 1'b1);
    frame_ready = 1'b1;
    send_tbl(0, N, N - 1);
    wait_fv();
    check("after_rst_frameA", llr0, exp_a0);
    tick();

    // Random frames against the arithmetic model.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      for (int k = 0; k < N; k++) samp[k] = 8'($urandom);
      if (kind == 0) begin
        len = $urandom_range(1, N);
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 2) == 0) tick();
          send(samp[k], (k == len - 1) && (len != N));
        end
        check($sformatf("rand_err_f%0d", f), err0, 1'b1);
        check($sformatf("rand_err_novalid_f%0d", f), fv0, 1'b0);
      end else begin
        exp_r0 = '0;
        exp_r1 = '0;
        for (int k = 0; k < N; k++) begin
          exp_r0[k*LLR_W +: LLR_W] = model(samp[k], 0);
          exp_r1[k*LLR_W +: LLR_W] = model(samp[k], 2);
          if ($urandom_range(0, 2) == 0) tick();
          send(samp[k], k == N - 1);
        end
        check($sformatf("rand_noerr_f%0d", f), err0, 1'b0);
        wait_fv();
        check($sformatf("rand_frame_dut0_f%0d", f), llr0, exp_r0);
        check($sformatf("rand_frame_dut1_f%0d", f), llr1, exp_r1);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
